sum_bcd_convert: RTL
====================

# sum_bcd_convert

Downstream stage of the 8-bit gated adder. It watches the adder's `enable` completion flag and, on its rising edge, captures the 9-bit sum. A sequential double-dabble (shift-and-add-3) converter then turns the sum into three BCD digits for the display/readout stage that follows. It produces one registered result and a single-cycle `valid` pulse for each rising edge of `enable`.

## Interface
- `SUM_W`, default 9: width of the input sum. The adder's 8+8+carry result gives a maximum of 511.
- `DIGITS`, default 3: number of BCD output digits. It must satisfy 10^DIGITS > 2^SUM_W − 1. The values are checked by elaboration-time assertion.
- `sys_clk` in 1: single clock, all logic on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: completion level from the adder. Only a 0→1 transition starts a conversion.
- `sum` in SUM_W: adder result, sampled only on the start edge.
- `bcd` out 4*DIGITS: packed digits, ones in [3:0], tens in [7:4], hundreds in [11:8]. Reset value 0.
- `valid` out 1: one-cycle pulse when `bcd` has just been updated. Reset value 0.
- `busy` out 1: high while a conversion is in progress. Reset value 0.

## Operation
- Edge detect: `enable_q` is a register holding the previous `enable`, reset to 0. The start condition is `enable & ~enable_q`.
- FSM states: IDLE, CONV, DONE. Reset enters IDLE.
- IDLE:
  - On start: load `sum` into the shift register, clear the working BCD register, set the step counter to SUM_W, go to CONV, set `busy`=1.
  - Otherwise hold. `bcd` keeps its last value.
- CONV, each cycle:
  - First, every working digit ≥5 gets +3 (4-bit add, no carry out).
  - Then {working BCD, shift register} shifts left one bit, with the sum MSB entering the ones LSB.
  - The counter decrements. When the counter goes 1→0, go to DONE.
- DONE, one cycle:
  - Copy the working BCD to `bcd`, set `valid`=1, clear `busy`, go to IDLE.
  - `valid` clears on the following edge.
- Start while CONV or DONE: ignored, not queued. `enable_q` still tracks `enable`, so a held-high `enable` never retriggers. Only a low-then-high transition does.
- `sum` changes after the start edge: ignored. The captured value is converted.
- `enable` already high at reset release: `enable_q`=0, so the first edge is a start and the current `sum` is converted.
- Reset mid-conversion: all registers return to reset values immediately (asynchronously). No `valid` is produced and `bcd` reads 0.
- Arithmetic: each digit stays in 0–9 after the final shift for any in-range sum. The hundreds digit is at most 5 for SUM_W=9.

## Timing
- E0 is the edge that samples the start condition (load).
- E1..E9 (SUM_W edges) are the shift steps.
- E10: `bcd` is updated and `valid` rises.
- E11: `valid` falls.
- Latency from start edge to `valid` is SUM_W+1 = 10 cycles.
- `busy` is high from E0 to E10, i.e. 10 cycles.
- Back-to-back: a new start is accepted no earlier than E11, when the FSM is back in IDLE.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `sum_bcd_pkg` holds:
  - the state enum (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - the default SUM_W/DIGITS constants;
  - the counter width $clog2(SUM_W+1).
- One sub-module, `bcd_digit_adj`: combinational, 4-bit in/out, output = in ≥5 ? in+3 : in. It is instantiated DIGITS times via generate.
- The top contains the edge detect, FSM, counter, shift register and output registers.

## Test plan
- Reset, then pulse `enable` 0→1 with `sum`=9'd0 → at E10 `bcd`=12'h000 and `valid`=1 for exactly one cycle. `busy` is high for 10 cycles.
- `sum`=9'd511 → `bcd`=12'h511. Repeat with `sum`=9'd255 → `bcd`=12'h255, and `sum`=9'd100 → `bcd`=12'h100.
- Start with `sum`=9'd398, change `sum` to 9'd7 at E3 → `bcd`=12'h398.
- Hold `enable` high for 40 cycles after a start → exactly one `valid` pulse. Drop `enable` to 0 for 2 cycles, raise it again with `sum`=9'd42 → second pulse with `bcd`=12'h042.
- Assert `sys_rst_n`=0 between E5 and E6 of a conversion of 9'd300 → `bcd`=0, `busy`=0, no `valid`. After release with `enable` held high → new conversion completes 10 cycles after the first edge.
- Random sweep of all 512 sums via enable toggling → `bcd` matches a decimal reference model for every value.

Source files
------------

// File: rtl/sum_bcd_convert_pkg.sv
// Shared types and constants for the sum-to-BCD converter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUM_W_DEF  = 9;
    localparam int DIGITS_DEF = 3;
    localparam int CNT_W_DEF  = $clog2(SUM_W_DEF + 1);

    // Step counter must hold the value SUM_W itself.
    function automatic int cnt_width(input int sum_w);
        return $clog2(sum_w + 1);
    endfunction

    // True when DIGITS decimal digits can represent every SUM_W-bit value.
    function automatic bit digits_fit(input int digits, input int sum_w);
        longint p10;
        longint max_sum;
        p10     = 1;
        max_sum = (longint'(1) << sum_w) - 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        return p10 > max_sum;
    endfunction

endpackage

// File: rtl/sum_bcd_convert_if.sv
// Bus between the gated adder and the BCD converter.
// Latency: n/a (wires only).
// Backpressure: none; the adder's enable edge is a fire-and-forget request.
interface sum_bcd_convert_if
    import sum_bcd_pkg::*;
#(
    parameter int SUM_W  = SUM_W_DEF,
    parameter int DIGITS = DIGITS_DEF
);
    logic                  enable;
    logic [SUM_W-1:0]      sum;
    logic [4*DIGITS-1:0]   bcd;
    logic                  valid;
    logic                  busy;

    // Adder / stimulus side.
    modport master (output enable, output sum, input bcd, input valid, input busy);
    // Converter side.
    modport slave  (input enable, input sum, output bcd, output valid, output busy);
endinterface

// File: rtl/sum_bcd_convert_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_o
);
    // 4-bit add, carry discarded; in-range digits never overflow.
    assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;
endmodule

// File: rtl/sum_bcd_convert.sv
// Captures the adder sum on each enable rising edge and converts it to BCD by double-dabble.
// Latency: SUM_W+1 cycles from the start edge to the valid pulse; outputs fully registered.
// Backpressure: none; starts seen while busy are dropped, not queued.
module sum_bcd_convert
    import sum_bcd_pkg::*;
#(
    parameter int SUM_W  = SUM_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    sum_bcd_convert_if.slave  bus
);
    localparam int CNT_W = cnt_width(SUM_W);
    localparam int BCD_W = 4 * DIGITS;

    // Reject digit counts that cannot hold the largest sum.
    if (!digits_fit(DIGITS, SUM_W)) begin : g_bad_params
        $error("sum_bcd_convert: DIGITS too small for SUM_W");
    end

    state_t             state_q, state_d;
    logic               enable_q;
    logic [SUM_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               start;

    // A start is a low-to-high transition of enable; a held level never retriggers.
    assign start = bus.enable & ~enable_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (work_q[4*g +: 4]),
            .dig_o (work_adj[4*g +: 4])
        );
    end

    // Next-state and datapath: load on start, adjust-then-shift per step, publish in DONE.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bus.sum;
                    work_d  = '0;
                    cnt_d   = CNT_W'(SUM_W);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                {work_d, shift_d} = {work_adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = work_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            shift_q  <= '0;
            work_q   <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= bus.enable;
            shift_q  <= shift_d;
            work_q   <= work_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.bcd   = bcd_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule
